dla_conv_ctrl: RTL
==================

# dla_conv_ctrl

Sequencing controller for the DLA 3x3 convolution pipeline: the multiplier stage followed by the adder-tree register stages. It walks every valid 3x3 window position of a feature map in row-major order and requests each window's operands from the line-buffer/fetch side. It tracks which pipeline slots hold live data, drives the common `stall` that freezes every pipeline stage, and presents a valid/ready result stream with a last-beat marker. It sits between the DLA command logic (start/done) and the mul/adder pipeline registers.

## Interface
- `DIM_W`, 8: width of image dimension inputs and window coordinate outputs.
- `PIPE_DEPTH`, 4: number of register stages from window grant to result (multiplier plus adder stages); must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  launch a convolution pass; accepted only in IDLE.
- `img_w`  in  DIM_W  feature-map width; sampled on accepted `start`.
- `img_h`  in  DIM_W  feature-map height; sampled on accepted `start`.
- `win_req`  out  1  request operands for window (`win_row`, `win_col`).
- `win_gnt`  in  1  operands for the requested window enter the multiplier stage this cycle.
- `win_row`  out  DIM_W  top-left row of the current window.
- `win_col`  out  DIM_W  top-left column of the current window.
- `stall`  out  1  hold all pipeline stages.
- `out_valid`  out  1  pipeline result at final stage is valid.
- `out_ready`  in  1  consumer accepts result.
- `out_last`  out  1  qualifies `out_valid`: final window of the pass.
- `busy`  out  1  pass in progress (ISSUE or DRAIN).
- `done`  out  1  one-cycle pulse at pass completion.
- `stall_cycles`  out  32  present only with `DLA_CTRL_PERF_EN`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on `start`, latch `img_w`/`img_h` and clear `win_row`/`win_col`. If either dimension is < 3, go to DONE. Otherwise go to ISSUE. All other inputs are ignored in IDLE.
- ISSUE: `win_req` = !`stall`. A fire is `win_req && win_gnt`.
  - On a fire, `win_col` increments. At `img_w-3`, `win_col` wraps to 0 and `win_row` increments.
  - The fire of window (`img_h-3`, `img_w-3`) moves the FSM to DRAIN.
- DRAIN: `win_req` = 0. On `out_valid && out_ready && out_last`, go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `start` is ignored while not in IDLE.
- Valid tracking uses a PIPE_DEPTH-bit shift register `vsr`, plus a parallel last-flag register `lsr`.
  - Bit 0 input is the fire; the `lsr` bit 0 input is fire of the final window.
  - `out_valid` = `vsr[PIPE_DEPTH-1]`; `out_last` = `lsr[PIPE_DEPTH-1] & out_valid`.
- `stall` = `out_valid && !out_ready`.
  - While stalled, `vsr`, `lsr` and the coordinate counters hold.
  - While not stalled, `vsr` and `lsr` shift every cycle.
  - Bubbles (0 bits) are not compressed.
- `busy` = 1 in ISSUE and DRAIN.
- Counts: windows per pass = (`img_w`-2)×(`img_h`-2). Counter arithmetic is unsigned DIM_W bits; maximum dimension is 2^DIM_W-1.

## Timing
- Reset values: FSM = IDLE; `vsr`, `lsr`, counters and latched dims = 0. Outputs `win_req`, `win_row`, `win_col`, `stall`, `out_valid`, `out_last`, `busy`, `done` = 0. `stall_cycles` = 0.
- `rst` mid-pass aborts immediately. No `done` pulse is generated, and all in-flight valids are discarded.
- `start` accepted in cycle t: ISSUE and `busy` = 1 from t+1.
- Degenerate dimensions: DONE in t+1, `done` = 1 in t+1, IDLE in t+2.
- Latency: a window fired in cycle t shows `out_valid` in cycle t+PIPE_DEPTH, plus one cycle per stall cycle in between.
- Throughput: one window per cycle with `win_gnt` = 1 and `out_ready` = 1.
- Final handshake in cycle t: `done` = 1 in t+1, `busy` = 0 in t+1, IDLE in t+2. A `start` is accepted in t+2 at the earliest.
- When the final fire coincides with a stall, the stall wins: no fire occurs and the FSM remains in ISSUE.

## Configuration
- `DLA_CTRL_PERF_EN` defined: `stall_cycles` port exists.
  - Counts cycles with `stall` = 1 while `busy` = 1, and saturates at 2^32-1.
  - Cleared on accepted `start`; holds its value after `done`.
- `DLA_CTRL_PERF_EN` not defined: port and counter are absent; all other behaviour is identical.

## Test plan
- 5×5 image, PIPE_DEPTH=4, `win_gnt`=1, `out_ready`=1, `start` at cycle 0:
  - Fires occur in cycles 1–9 with coordinates (0,0),(0,1),(0,2),(1,0)…(2,2).
  - `out_valid` is high in cycles 5–13, with `out_last` only in 13.
  - `done` pulses in 14.
- Same setup with `out_ready` = 0 for cycles 5–7:
  - `stall` is high in 5–7, `win_req` is low in 5–7, and the coordinates hold.
  - Result (0,0) is accepted in 8; `done` pulses in 17.
- Same setup with `win_gnt` low every other cycle: exactly 9 `out_valid` beats, bubbles between beats, `out_last` on the 9th beat.
- `img_w`=2, `img_h`=7, `start` at 0: `done` in 1, no `win_req` or `out_valid` ever, `busy` stays 0.
- Mid-pass events:
  - `start` pulsed during ISSUE has no effect.
  - `rst` asserted in ISSUE (cycle 4 of the 5×5 case) returns all outputs to 0 next cycle, and no `done` pulse follows.
- With `DLA_CTRL_PERF_EN`, the backpressure case gives `stall_cycles` = 3 after `done`. A second `start` resets it to 0.

Source files
------------

// File: rtl/dla_conv_ctrl_if.sv
// dla_conv_ctrl_if
// Bundles the two handshakes of the convolution controller:
//   window fetch : win_req / win_gnt with the requested window's top-left
//                  corner win_row / win_col
//   result stream: out_valid / out_ready with the last-beat marker out_last
// Modports:
//   master - the controller (drives requests, coordinates, result valid/last)
//   slave  - the fetch side and result consumer (drive grant and ready)
interface dla_conv_ctrl_if #(
  parameter int DIM_W = 8
);
  logic             win_req;
  logic             win_gnt;
  logic [DIM_W-1:0] win_row;
  logic [DIM_W-1:0] win_col;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output win_req, win_row, win_col, out_valid, out_last,
    input  win_gnt, out_ready
  );

  modport slave (
    input  win_req, win_row, win_col, out_valid, out_last,
    output win_gnt, out_ready
  );
endinterface

// File: rtl/dla_conv_ctrl.sv
// dla_conv_ctrl
// Sequencing controller for the 3x3 convolution pipeline (multiplier stage
// followed by adder-tree stages). Walks every valid 3x3 window of an
// img_w x img_h feature map in row-major order, requests each window's
// operands, tracks live pipeline slots, drives the common stall and presents
// the result valid/ready stream with a last-beat marker.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - launch a pass (accepted only in IDLE)
//   img_w, img_h  - feature-map dimensions, sampled on accepted start
//   cif (master)  - window request/grant + coordinates, result valid/ready/last
//   stall         - freeze every pipeline stage
//   busy          - pass in progress (ISSUE or DRAIN)
//   done          - one-cycle pulse at pass completion
//   stall_cycles  - stalled cycles of the current/last pass
//                   (only when DLA_CTRL_PERF_EN is defined)
module dla_conv_ctrl #(
  parameter int DIM_W      = 8,
  parameter int PIPE_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] img_w,
  input  logic [DIM_W-1:0] img_h,
  dla_conv_ctrl_if.master  cif,
  output logic             stall,
  output logic             busy,
  output logic             done
`ifdef DLA_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DIM_W-1:0]      w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0]      row_q, row_d, col_q, col_d;
  logic [PIPE_DEPTH-1:0] vsr_q, vsr_d, lsr_q, lsr_d;
  logic                  fire, fire_last, col_end, row_end, start_acc;

  assign cif.out_valid = vsr_q[PIPE_DEPTH-1];
  assign cif.out_last  = lsr_q[PIPE_DEPTH-1] & cif.out_valid;
  assign stall         = cif.out_valid & ~cif.out_ready;
  // A stall blocks new grants so the multiplier stage is never overwritten.
  assign cif.win_req   = (state_q == S_ISSUE) & ~stall;
  assign cif.win_row   = row_q;
  assign cif.win_col   = col_q;
  assign busy          = (state_q == S_ISSUE) | (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);

  assign fire      = cif.win_req & cif.win_gnt;
  assign col_end   = (col_q == w_q - DIM_W'(3));
  assign row_end   = (row_q == h_q - DIM_W'(3));
  assign fire_last = fire & col_end & row_end;
  assign start_acc = (state_q == S_IDLE) & start;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = img_w;
          h_d     = img_h;
          row_d   = '0;
          col_d   = '0;
          // Fewer than 3 rows or columns means no valid window at all.
          state_d = ((img_w < DIM_W'(3)) || (img_h < DIM_W'(3))) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fire) begin
          if (col_end) begin
            col_d = '0;
            row_d = row_q + DIM_W'(1);
          end else begin
            col_d = col_q + DIM_W'(1);
          end
          if (fire_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cif.out_valid && cif.out_ready && cif.out_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Slot tracking: shifts with the pipeline, holds while stalled, bubbles kept.
    vsr_d = vsr_q;
    lsr_d = lsr_q;
    if (!stall) begin
      vsr_d = (vsr_q << 1) | PIPE_DEPTH'(fire);
      lsr_d = (lsr_q << 1) | PIPE_DEPTH'(fire_last);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      vsr_q   <= '0;
      lsr_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      row_q   <= row_d;
      col_q   <= col_d;
      vsr_q   <= vsr_d;
      lsr_q   <= lsr_d;
    end
  end

`ifdef DLA_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (start_acc) begin
      stall_cycles_d = '0;
    end else if (stall && busy && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= '0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
